// File: rtl/arb_pkg.sv
// Shared definitions for the request aging unit and the downstream priority arbiter.
package arb_pkg;

    localparam int unsigned N_SRC    = 3;
    localparam int unsigned PRIO_W   = 3;
    localparam int unsigned MAX_PRIO = 7;
    localparam int unsigned AGE_W    = 8;

    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [AGE_W-1:0]  age_t;

    // Bit offset of source i's field inside the packed prios bus.
    function automatic int unsigned prio_lsb(input int unsigned src);
        return src * PRIO_W;
    endfunction

endpackage

// File: rtl/age_slot.sv
// One source's pending request: posting, aging of its effective priority, and grant retirement.
module age_slot
    import arb_pkg::*;
#(
    parameter int unsigned AGE_PERIOD = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_req,
    input  prio_t i_base_prio,
    input  logic  i_gnt,
    output logic  o_pending,
    output prio_t o_prio,
    output logic  o_done
);

    localparam age_t  AgeLast = age_t'(AGE_PERIOD - 1);
    localparam prio_t PrioTop = prio_t'(MAX_PRIO);

    logic  r_pending;
    prio_t r_prio;
    age_t  r_age;
    logic  r_done;

    // Post, age, and retire the request; a grant with a same-cycle post reloads instead of retiring.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_prio    <= '0;
            r_age     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_pending) begin
                // A grant here is spurious; it is flagged in the top and otherwise ignored.
                if (i_req) begin
                    r_pending <= 1'b1;
                    r_prio    <= i_base_prio;
                    r_age     <= '0;
                end
            end else if (i_gnt) begin
                r_done <= 1'b1;
                if (i_req) begin
                    r_prio <= i_base_prio;
                    r_age  <= '0;
                end else begin
                    r_pending <= 1'b0;
                end
            end else if (r_age == AgeLast) begin
                r_age <= '0;
                if (r_prio != PrioTop) begin
                    r_prio <= r_prio + prio_t'(1);
                end
            end else begin
                r_age <= r_age + age_t'(1);
            end
        end
    end

    assign o_pending = r_pending;
    assign o_prio    = r_pending ? r_prio : '0;
    assign o_done    = r_done;

endmodule

// File: rtl/req_aging_unit.sv
// Ages pending per-source requests into rising priorities for a downstream priority arbiter.
module req_aging_unit
    import arb_pkg::*;
#(
    parameter int unsigned AGE_PERIOD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_req,
    input  logic [N_SRC*PRIO_W-1:0]  src_base_prio,
    input  logic [N_SRC-1:0]         gnt,
    output logic [N_SRC-1:0]         req,
    output logic [N_SRC*PRIO_W-1:0]  prios,
    output logic [N_SRC-1:0]         src_busy,
    output logic [N_SRC-1:0]         src_done,
    output logic                     err_spurious
);

    logic [N_SRC-1:0] w_pending;
    logic [N_SRC-1:0] w_done;
    prio_t            w_prio [N_SRC];
    logic             w_spurious;
    logic             w_multi_gnt;
    logic             r_err;

    for (genvar i = 0; i < N_SRC; i++) begin : g_slot
        age_slot #(
            .AGE_PERIOD (AGE_PERIOD)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_req       (src_req[i]),
            .i_base_prio (src_base_prio[prio_lsb(i) +: PRIO_W]),
            .i_gnt       (gnt[i]),
            .o_pending   (w_pending[i]),
            .o_prio      (w_prio[i]),
            .o_done      (w_done[i])
        );
    end

    assign w_spurious  = |(gnt & ~w_pending);
    assign w_multi_gnt = (gnt & (gnt - 1'b1)) != '0;

    // Sticky error for a grant to an idle source or a non-one-hot grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_spurious || w_multi_gnt) begin
            r_err <= 1'b1;
        end
    end

    // Pack per-source effective priorities into the arbiter-facing bus.
    always_comb begin
        prios = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            prios[prio_lsb(i) +: PRIO_W] = w_prio[i];
        end
    end

    // Mask the request being granted this cycle so the registered arbiter cannot re-grant it.
    assign req          = w_pending & ~gnt;
    assign src_busy     = w_pending;
    assign src_done     = w_done;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_req_aging_unit.sv
// Directed self-checking bench for req_aging_unit (AGE_PERIOD = 4).
module tb_req_aging_unit;

    logic       clk;
    logic       rst;
    logic [2:0] src_req;
    logic [8:0] src_base_prio;
    logic [2:0] gnt;
    logic [2:0] req;
    logic [8:0] prios;
    logic [2:0] src_busy;
    logic [2:0] src_done;
    logic       err_spurious;

    int errors = 0;
    int checks = 0;

    req_aging_unit #(
        .AGE_PERIOD (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_req       (src_req),
        .src_base_prio (src_base_prio),
        .gnt           (gnt),
        .req           (req),
        .prios         (prios),
        .src_busy      (src_busy),
        .src_done      (src_done),
        .err_spurious  (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; src_req = 3'b111; src_base_prio = 9'o777; gnt = 3'b000;
        tick(); tick();
        checks++; if (req !== 3'b000) begin errors++; $display("FAIL rst_req: got %b want 000", req); end
        checks++; if (prios !== 9'd0) begin errors++; $display("FAIL rst_prios: got %o want 0", prios); end
        checks++; if (src_busy !== 3'b000) begin errors++; $display("FAIL rst_busy: got %b want 000", src_busy); end
        checks++; if (src_done !== 3'b000) begin errors++; $display("FAIL rst_done: got %b want 000", src_done); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_spurious); end
        rst = 1'b0; src_req = 3'b000; src_base_prio = '0;
        tick();
        checks++; if (src_busy !== 3'b000) begin errors++; $display("FAIL rst_lost_post: busy %b want 000", src_busy); end
    endtask

    task automatic test_aging();
        src_req = 3'b001; src_base_prio = 9'o002;
        tick();
        src_req = 3'b000; src_base_prio = '0;
        checks++; if (prios[2:0] !== 3'd2) begin errors++; $display("FAIL age_t1: prio0 %0d want 2", prios[2:0]); end
        checks++; if (req !== 3'b001) begin errors++; $display("FAIL age_req: got %b want 001", req); end
        tick(); tick(); tick();
        checks++; if (prios[2:0] !== 3'd2) begin errors++; $display("FAIL age_t4: prio0 %0d want 2", prios[2:0]); end
        tick();
        checks++; if (prios[2:0] !== 3'd3) begin errors++; $display("FAIL age_t5: prio0 %0d want 3", prios[2:0]); end
        for (int k = 0; k < 4; k++) tick();
        checks++; if (prios[2:0] !== 3'd4) begin errors++; $display("FAIL age_t9: prio0 %0d want 4", prios[2:0]); end
        gnt = 3'b001;
        tick();
        gnt = 3'b000;
        checks++; if (src_busy !== 3'b000) begin errors++; $display("FAIL age_clear: busy %b want 000", src_busy); end
        checks++; if (prios !== 9'd0) begin errors++; $display("FAIL age_idle_prio: got %o want 0", prios); end
        tick();
    endtask

    task automatic test_saturate();
        src_req = 3'b010; src_base_prio = 9'o060;
        tick();
        src_req = 3'b000; src_base_prio = '0;
        checks++; if (prios[5:3] !== 3'd6) begin errors++; $display("FAIL sat_t1: prio1 %0d want 6", prios[5:3]); end
        for (int k = 0; k < 4; k++) tick();
        checks++; if (prios[5:3] !== 3'd7) begin errors++; $display("FAIL sat_t5: prio1 %0d want 7", prios[5:3]); end
        for (int k = 0; k < 8; k++) tick();
        checks++; if (prios[5:3] !== 3'd7) begin errors++; $display("FAIL sat_t13: prio1 %0d want 7", prios[5:3]); end
        checks++; if (req !== 3'b010) begin errors++; $display("FAIL sat_req: got %b want 010", req); end
        gnt = 3'b010;
        tick();
        gnt = 3'b000;
        tick();
    endtask

    task automatic test_grant();
        src_req = 3'b100; src_base_prio = 9'o300;
        tick();
        src_req = 3'b000; src_base_prio = '0;
        tick();
        gnt = 3'b100;
        #1;
        checks++; if (req !== 3'b000) begin errors++; $display("FAIL gnt_mask: req %b want 000", req); end
        tick();
        gnt = 3'b000;
        checks++; if (src_done !== 3'b100) begin errors++; $display("FAIL gnt_done: got %b want 100", src_done); end
        checks++; if (src_busy !== 3'b000) begin errors++; $display("FAIL gnt_busy: got %b want 000", src_busy); end
        tick();
        checks++; if (src_done !== 3'b000) begin errors++; $display("FAIL gnt_done_once: got %b want 000", src_done); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL gnt_err: got %b want 0", err_spurious); end
    endtask

    task automatic test_back_to_back();
        src_req = 3'b001; src_base_prio = 9'o005;
        tick();
        src_req = 3'b000;
        tick(); tick();
        gnt = 3'b001; src_req = 3'b001; src_base_prio = 9'o001;
        tick();
        gnt = 3'b000; src_req = 3'b000; src_base_prio = '0;
        checks++; if (src_done !== 3'b001) begin errors++; $display("FAIL b2b_done: got %b want 001", src_done); end
        checks++; if (src_busy !== 3'b001) begin errors++; $display("FAIL b2b_busy: got %b want 001", src_busy); end
        checks++; if (prios[2:0] !== 3'd1) begin errors++; $display("FAIL b2b_prio: got %0d want 1", prios[2:0]); end
        tick(); tick(); tick();
        checks++; if (prios[2:0] !== 3'd1) begin errors++; $display("FAIL b2b_age3: prio0 %0d want 1", prios[2:0]); end
        checks++; if (src_done !== 3'b000) begin errors++; $display("FAIL b2b_done_once: got %b want 000", src_done); end
        tick();
        checks++; if (prios[2:0] !== 3'd2) begin errors++; $display("FAIL b2b_age4: prio0 %0d want 2", prios[2:0]); end
        gnt = 3'b001;
        tick();
        gnt = 3'b000;
        tick();
    endtask

    task automatic test_spurious();
        src_req = 3'b101; src_base_prio = 9'o204;
        tick();
        src_req = 3'b000; src_base_prio = '0;
        gnt = 3'b010;
        tick();
        gnt = 3'b000;
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_set: got %b want 1", err_spurious); end
        checks++; if (src_busy !== 3'b101) begin errors++; $display("FAIL spur_busy: got %b want 101", src_busy); end
        checks++; if (src_done !== 3'b000) begin errors++; $display("FAIL spur_done: got %b want 000", src_done); end
        checks++; if (prios !== 9'o204) begin errors++; $display("FAIL spur_prios: got %o want 204", prios); end
        tick(); tick(); tick();
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b want 1", err_spurious); end
        gnt = 3'b101;
        tick();
        gnt = 3'b000;
        checks++; if (src_done !== 3'b101) begin errors++; $display("FAIL spur_multi_done: got %b want 101", src_done); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spur_rst: got %b want 0", err_spurious); end
        // Two valid grants at once still flag a non-one-hot grant.
        src_req = 3'b011; src_base_prio = '0;
        tick();
        src_req = 3'b000;
        gnt = 3'b011;
        tick();
        gnt = 3'b000;
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL multi_err: got %b want 1", err_spurious); end
        checks++; if (src_done !== 3'b011) begin errors++; $display("FAIL multi_done: got %b want 011", src_done); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        src_req = 3'b111; src_base_prio = 9'o555;
        tick();
        src_req = 3'b000; src_base_prio = '0;
        tick(); tick();
        checks++; if (prios !== 9'o555) begin errors++; $display("FAIL rmid_prios: got %o want 555", prios); end
        rst = 1'b1; gnt = 3'b111;
        tick();
        rst = 1'b0; gnt = 3'b000;
        checks++; if (req !== 3'b000) begin errors++; $display("FAIL rmid_req: got %b want 000", req); end
        checks++; if (prios !== 9'd0) begin errors++; $display("FAIL rmid_prios0: got %o want 0", prios); end
        checks++; if (src_busy !== 3'b000) begin errors++; $display("FAIL rmid_busy: got %b want 000", src_busy); end
        checks++; if (src_done !== 3'b000) begin errors++; $display("FAIL rmid_done: got %b want 000", src_done); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", err_spurious); end
        tick();
        checks++; if (src_done !== 3'b000) begin errors++; $display("FAIL rmid_done_late: got %b want 000", src_done); end
    endtask

    initial begin
        rst = 1'b1; src_req = '0; src_base_prio = '0; gnt = '0;
        test_reset();
        test_aging();
        test_saturate();
        test_grant();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_aging_unit.md
REQ_AGING_UNIT -- requirements
Module: req_aging_unit

Interface
REQ-001 Parameter AGE_PERIOD, default 4, range 1..255: waiting cycles per one-step priority increase.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-004 src_req  input  3  per-source request-post strobe, bit i = source i.
REQ-005 src_base_prio  input  9  base priorities, source i at [3i+2:3i], sampled only on accepted post.
REQ-006 gnt  input  3  one-hot grant returned by the downstream priority arbiter.
REQ-007 req  output  3  pending requests presented to the arbiter.
REQ-008 prios  output  9  effective (aged) priorities, source i at [3i+2:3i].
REQ-009 src_busy  output  3  source i has a request pending.
REQ-010 src_done  output  3  one-cycle pulse: source i request granted.
REQ-011 err_spurious  output  1  sticky: a grant arrived for a non-pending source.

Function
REQ-012 Each source i SHALL hold state {pending, eff_prio[2:0], age_cnt[7:0]}, updated independently.
REQ-013 Post: src_req[i]=1 and pending=0 SHALL set pending=1, eff_prio=src_base_prio[i], age_cnt=0 next cycle.
REQ-014 src_req[i]=1 while pending=1 and gnt[i]=0 SHALL be ignored; no state change.
REQ-015 Aging: pending=1 and gnt[i]=0 SHALL increment age_cnt each cycle; when age_cnt==AGE_PERIOD-1, age_cnt SHALL return to 0 and eff_prio SHALL increase by 1.
REQ-016 eff_prio SHALL saturate at 7; age_cnt keeps cycling at 7 with no wrap of eff_prio to 0.
REQ-017 Grant: gnt[i]=1 with pending=1 SHALL clear pending next cycle and assert src_done[i] for exactly that next cycle.
REQ-018 Simultaneous grant and post (gnt[i]=1, src_req[i]=1, pending=1): src_done[i] SHALL pulse, pending SHALL stay 1, eff_prio reloads src_base_prio[i], age_cnt=0.
REQ-019 req[i] SHALL equal pending[i] AND NOT gnt[i] (combinational mask) so the registered arbiter never re-grants the same request.
REQ-020 prios[3i+2:3i] SHALL equal eff_prio of source i, registered; value for non-pending sources SHALL be 0.
REQ-021 src_busy[i] SHALL equal pending[i], registered.
REQ-022 gnt[i]=1 with pending=0 SHALL set err_spurious=1, held until rst; source i state unchanged unless REQ-013 applies.
REQ-023 gnt with more than one bit set SHALL be processed per bit and SHALL also set err_spurious.
REQ-024 Latency: post at cycle t -> req[i]=1 at t+1; grant at cycle g -> src_done[i]=1 and src_busy[i]=0 at g+1.

Reset
REQ-025 rst=1 at a clock edge SHALL clear pending, eff_prio, age_cnt for all sources, src_done, err_spurious.
REQ-026 Reset values: req=0, prios=0, src_busy=0, src_done=0, err_spurious=0.
REQ-027 rst SHALL override any concurrent src_req or gnt; requests posted during reset are lost.
REQ-028 Reset mid-aging SHALL discard pending state with no src_done pulse.

Structure
REQ-029 Shared package arb_pkg SHALL hold N_SRC=3, PRIO_W=3, MAX_PRIO=7 and the prios field packing offsets, shared with the priority arbiter.
REQ-030 Per-source logic SHALL be a sub-module age_slot, instantiated N_SRC times; top holds err_spurious and output packing.

Verification
REQ-031 Post src0 base 2, AGE_PERIOD=4, no grant -> prios[2:0] = 2,3,4 at cycles t+1, t+5, t+9; req=001.
REQ-032 Post src1 base 6, hold 12 cycles ungranted -> prios[5:3] reaches 7 and stays 7; no wrap.
REQ-033 src2 pending, gnt=100 at cycle g -> req[2]=0 at g, src_done=100 at g+1 only, src_busy[2]=0 at g+1.
REQ-034 src0 pending, gnt=001 with src_req=001 base 1 same cycle -> src_done[0]=1, src_busy[0]=1, prios[2:0]=1, aging restarts.
REQ-035 gnt=010 with src1 idle -> err_spurious=1 next cycle, stays 1 until rst; other sources unaffected.
REQ-036 rst asserted while all three pending at eff_prio 5 -> next cycle all outputs 0, no src_done.
